// File: rtl/inpdt_pkg.sv
// Shared sizing helpers and accumulator state type for the inner-product accumulator.
package inpdt_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } acc_state_e;

  // Ceiling log2, used for elaboration-time sizing (0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Cycles from the cycle a last beat is presented to the cycle oValid rises.
  function automatic int LAT(input int lanes);
    return clog2(lanes) + 3;
  endfunction

endpackage

// File: rtl/inpdt_tree.sv
// Registered binary adder tree: one register level per tree level, sideband carried alongside.
module inpdt_tree
  import inpdt_pkg::*;
#(
  parameter int LANES = 16,
  parameter int IN_W  = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic                           valid_i,
  input  logic                           last_i,
  input  logic                           signed_i,
  input  logic [LANES*IN_W-1:0]          data_i,
  output logic                           valid_o,
  output logic                           last_o,
  output logic                           signed_o,
  output logic [IN_W+clog2(LANES)-1:0]   sum_o
);
  localparam int LVLS  = clog2(LANES);
  localparam int OUT_W = IN_W + LVLS;

  // Heap numbering: node i has children 2i and 2i+1; nodes 1..LANES-1 are
  // registered sums (root = 1), nodes LANES..2*LANES-1 are the extended leaves.
  logic [OUT_W-1:0] node_s [2*LANES];
  logic [OUT_W-1:0] node_q [LANES];
  logic [LVLS-1:0]  valid_q;
  logic [LVLS-1:0]  last_q;
  logic [LVLS-1:0]  signed_q;

  // Build the heap view; leaves are sign- or zero-extended so every sum is exact.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      node_s[i] = node_q[i];
      node_s[LANES + i] = signed_i ? OUT_W'($signed(data_i[i*IN_W +: IN_W]))
                                   : OUT_W'(data_i[i*IN_W +: IN_W]);
    end
  end

  // All tree levels and sideband advance together; a stall freezes everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LANES; i++) node_q[i] <= '0;
      valid_q  <= '0;
      last_q   <= '0;
      signed_q <= '0;
    end else if (en_i) begin
      node_q[0] <= '0;
      for (int i = 1; i < LANES; i++) node_q[i] <= node_s[2*i] + node_s[2*i+1];
      valid_q[0]  <= valid_i;
      last_q[0]   <= last_i;
      signed_q[0] <= signed_i;
      for (int j = 1; j < LVLS; j++) begin
        valid_q[j]  <= valid_q[j-1];
        last_q[j]   <= last_q[j-1];
        signed_q[j] <= signed_q[j-1];
      end
    end
  end

  assign valid_o  = valid_q[LVLS-1];
  assign last_o   = last_q[LVLS-1];
  assign signed_o = signed_q[LVLS-1];
  assign sum_o    = node_q[1];

endmodule

// File: rtl/inpdt_acc.sv
// Pipelined LANES-wide dot product with per-frame accumulation and overflow flag.
module inpdt_acc
  import inpdt_pkg::*;
#(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int ACC_W = 32
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [LANES*DW-1:0]   iData_X,
  input  logic [LANES*DW-1:0]   iData_W,
  input  logic                  iValid,
  input  logic                  iLast,
  input  logic                  iSigned,
  output logic                  oReady,
  output logic [ACC_W-1:0]      oResult,
  output logic                  oOverflow,
  output logic                  oValid,
  input  logic                  iReady
);
  localparam int LVLS   = clog2(LANES);
  localparam int PROD_W = 2 * DW;
  localparam int PART_W = PROD_W + LVLS;

  logic                    en_s;
  logic                    beat_sgn_s;
  logic [LANES*DW-1:0]     x_q, w_q;
  logic                    v0_q, l0_q, s0_q;
  logic                    open_q, sgn_lat_q;
  logic [LANES*PROD_W-1:0] prod_d, prod_q;
  logic                    v1_q, l1_q, s1_q;
  logic                    tv_s, tl_s, ts_s;
  logic [PART_W-1:0]       tsum_s;
  logic [ACC_W-1:0]        partial_s, sum_s;
  logic                    sovf_s;
  acc_state_e              state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d, res_q, res_d;
  logic                    aovf_q, aovf_d, rovf_q, rovf_d, vld_q, vld_d;

  // Exact lane product; operands extended one bit so both modes share a signed multiply.
  function automatic logic [PROD_W-1:0] lane_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                 input logic sgn);
    logic signed [DW:0]       ea, eb;
    logic signed [PROD_W+1:0] p;
    ea = {sgn & a[DW-1], a};
    eb = {sgn & b[DW-1], b};
    p  = ea * eb;
    return p[PROD_W-1:0];
  endfunction

  // Range overflow of a + b in the frame's latched signedness.
  function automatic logic add_ovf(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                                   input logic sgn);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (sgn) return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    else     return s[ACC_W];
  endfunction

  assign en_s       = !(vld_q && !iReady);
  assign oReady     = en_s;
  assign beat_sgn_s = open_q ? sgn_lat_q : iSigned;

  // Input register; signedness is latched by the first beat of each frame.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      x_q <= '0; w_q <= '0; v0_q <= 1'b0; l0_q <= 1'b0; s0_q <= 1'b0;
      open_q <= 1'b0; sgn_lat_q <= 1'b0;
    end else if (en_s) begin
      x_q  <= iData_X;
      w_q  <= iData_W;
      v0_q <= iValid;
      l0_q <= iLast;
      s0_q <= beat_sgn_s;
      if (iValid) begin
        open_q    <= !iLast;
        sgn_lat_q <= beat_sgn_s;
      end
    end
  end

  // Per-lane products from the input register.
  always_comb begin
    prod_d = '0;
    for (int k = 0; k < LANES; k++) begin
      prod_d[k*PROD_W +: PROD_W] = lane_mul(x_q[k*DW +: DW], w_q[k*DW +: DW], s0_q);
    end
  end

  // Product register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      prod_q <= '0; v1_q <= 1'b0; l1_q <= 1'b0; s1_q <= 1'b0;
    end else if (en_s) begin
      prod_q <= prod_d; v1_q <= v0_q; l1_q <= l0_q; s1_q <= s0_q;
    end
  end

  inpdt_tree #(.LANES(LANES), .IN_W(PROD_W)) u_tree (
    .clk_i    (iClk),
    .rst_i    (iRst),
    .en_i     (en_s),
    .valid_i  (v1_q),
    .last_i   (l1_q),
    .signed_i (s1_q),
    .data_i   (prod_q),
    .valid_o  (tv_s),
    .last_o   (tl_s),
    .signed_o (ts_s),
    .sum_o    (tsum_s)
  );

  assign partial_s = ts_s ? ACC_W'($signed(tsum_s)) : ACC_W'(tsum_s);

  // Accumulator FSM: load on frame start, add within a frame, publish on the last beat.
  always_comb begin
    state_d = state_q; acc_d = acc_q; aovf_d = aovf_q;
    res_d = res_q; rovf_d = rovf_q; vld_d = vld_q;
    sum_s = '0; sovf_s = 1'b0;
    if (en_s) begin
      vld_d = 1'b0;
      if (tv_s) begin
        case (state_q)
          ST_IDLE: begin sum_s = partial_s; sovf_s = 1'b0; end
          ST_RUN:  begin
            sum_s  = acc_q + partial_s;
            sovf_s = aovf_q | add_ovf(acc_q, partial_s, ts_s);
          end
          default: begin sum_s = partial_s; sovf_s = 1'b0; end
        endcase
        if (tl_s) begin
          state_d = ST_IDLE; acc_d = '0; aovf_d = 1'b0;
          res_d = sum_s; rovf_d = sovf_s; vld_d = 1'b1;
        end else begin
          state_d = ST_RUN; acc_d = sum_s; aovf_d = sovf_s;
        end
      end else begin
        state_d = state_q;
      end
    end else begin
      vld_d = vld_q;
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE; acc_q <= '0; aovf_q <= 1'b0;
      res_q <= '0; rovf_q <= 1'b0; vld_q <= 1'b0;
    end else begin
      state_q <= state_d; acc_q <= acc_d; aovf_q <= aovf_d;
      res_q <= res_d; rovf_q <= rovf_d; vld_q <= vld_d;
    end
  end

  assign oResult   = res_q;
  assign oOverflow = rovf_q;
  assign oValid    = vld_q;

endmodule

// File: tb/tb_inpdt_acc.sv
// Self-checking bench for inpdt_acc: vector table, hand sequences and a model-fed scoreboard.
module tb_inpdt_acc;
  localparam int LANES  = 16;
  localparam int DW     = 8;
  localparam int ACC_W  = 32;
  localparam int ACC_W2 = 21;
  localparam int LATENCY = 7;

  logic iClk = 1'b0;
  logic iRst;
  logic [LANES*DW-1:0] iData_X, iData_W;
  logic iValid, iValid2, iLast, iSigned, iReady, iReady2;
  logic oReady, oOverflow, oValid, oReady2, oOverflow2, oValid2;
  logic [ACC_W-1:0]  oResult;
  logic [ACC_W2-1:0] oResult2;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct { logic [ACC_W-1:0] res; logic ovf; } exp_t;
  typedef struct { logic [DW-1:0] x; logic [DW-1:0] w; logic sgn; logic [ACC_W-1:0] res; } vec_t;
  exp_t q[$];
  exp_t q2[$];
  int   res_cyc[$];
  vec_t tbl[8];

  // model state for the default-width instance
  logic       m_open, m_sgn, m_ovf;
  longint     m_acc;

  inpdt_acc dut (
    .iClk(iClk), .iRst(iRst), .iData_X(iData_X), .iData_W(iData_W),
    .iValid(iValid), .iLast(iLast), .iSigned(iSigned), .oReady(oReady),
    .oResult(oResult), .oOverflow(oOverflow), .oValid(oValid), .iReady(iReady)
  );

  inpdt_acc #(.ACC_W(ACC_W2)) dut21 (
    .iClk(iClk), .iRst(iRst), .iData_X(iData_X), .iData_W(iData_W),
    .iValid(iValid2), .iLast(iLast), .iSigned(iSigned), .oReady(oReady2),
    .oResult(oResult2), .oOverflow(oOverflow2), .oValid(oValid2), .iReady(iReady2)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard for the default instance: compare on every result handshake.
  always @(negedge iClk) begin
    exp_t e;
    if (!iRst && oValid && iReady) begin
      res_cyc.push_back(cyc);
      if (q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_result: got 0x%0h, expected no result", oResult);
      end else begin
        e = q.pop_front();
        check("result", 64'(oResult), 64'(e.res));
        check("overflow", 64'(oOverflow), 64'(e.ovf));
      end
    end
  end

  // Scoreboard for the 21-bit instance.
  always @(negedge iClk) begin
    exp_t e;
    if (!iRst && oValid2 && iReady2) begin
      if (q2.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_result21: got 0x%0h, expected no result", oResult2);
      end else begin
        e = q2.pop_front();
        check("result21", 64'(oResult2), 64'(e.res[ACC_W2-1:0]));
        check("overflow21", 64'(oOverflow2), 64'(e.ovf));
      end
    end
  end

  function automatic logic [LANES*DW-1:0] rep(input logic [DW-1:0] v);
    return {LANES{v}};
  endfunction

  function automatic longint lane_val(input logic [DW-1:0] v, input logic s);
    return s ? longint'($signed(v)) : longint'(v);
  endfunction

  // Reference model step for an accepted beat on the default instance.
  task automatic model_step(input logic [LANES*DW-1:0] x, input logic [LANES*DW-1:0] w,
                            input logic sgn, input logic last, input bit use_const,
                            input logic [ACC_W-1:0] cres, input logic covf);
    longint p, t;
    logic s_eff;
    s_eff = m_open ? m_sgn : sgn;
    p = 0;
    for (int k = 0; k < LANES; k++) p += lane_val(x[k*DW +: DW], s_eff) * lane_val(w[k*DW +: DW], s_eff);
    if (!m_open) begin
      m_acc = p & 64'hFFFF_FFFF;
      m_ovf = 1'b0;
    end else begin
      if (s_eff) begin
        t = longint'($signed(m_acc[31:0])) + p;
        if (t > 64'sd2147483647 || t < -64'sd2147483648) m_ovf = 1'b1;
      end else begin
        t = m_acc + p;
        if (t > 64'sd4294967295) m_ovf = 1'b1;
      end
      m_acc = t & 64'hFFFF_FFFF;
    end
    m_open = !last;
    m_sgn  = s_eff;
    if (last) begin
      if (use_const) q.push_back('{cres, covf});
      else           q.push_back('{m_acc[ACC_W-1:0], m_ovf});
    end
  endtask

  // Present one beat and hold it until accepted; expectations are queued on acceptance.
  task automatic send(input logic [LANES*DW-1:0] x, input logic [LANES*DW-1:0] w,
                      input logic sgn, input logic last, input bit to2, input bit use_const,
                      input logic [ACC_W-1:0] cres, input logic covf);
    int n;
    logic acc;
    iData_X = x; iData_W = w; iSigned = sgn; iLast = last;
    if (to2) iValid2 = 1'b1; else iValid = 1'b1;
    n = 0;
    do begin
      @(negedge iClk);
      acc = to2 ? oReady2 : oReady;
      @(posedge iClk); #1;
      n++;
    end while (!acc && n < 100);
    iValid = 1'b0; iValid2 = 1'b0;
    check("beat_accepted", 64'(acc), 64'd1);
    if (acc) begin
      if (to2) begin
        if (last) q2.push_back('{cres, covf});
      end else begin
        model_step(x, w, sgn, last, use_const, cres, covf);
      end
    end
  endtask

  task automatic rand_frame(input int nbeats);
    logic [LANES*DW-1:0] x, w;
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < LANES; k++) begin
        x[k*DW +: DW] = DW'($urandom_range(0, 255));
        w[k*DW +: DW] = DW'($urandom_range(0, 255));
      end
      send(x, w, 1'($urandom_range(0, 1)), (b == nbeats - 1), 1'b0, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || q2.size() != 0) && n < 300) begin
      @(posedge iClk); #1;
      n++;
    end
    check("drain_empty", 64'(q.size() + q2.size()), 64'd0);
    repeat (12) begin @(posedge iClk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_c, n;
    iRst = 1'b1; iValid = 1'b0; iValid2 = 1'b0; iLast = 1'b0; iSigned = 1'b0;
    iReady = 1'b1; iReady2 = 1'b1; iData_X = '0; iData_W = '0;
    m_open = 1'b0; m_sgn = 1'b0; m_ovf = 1'b0; m_acc = 0;
    repeat (3) @(posedge iClk);
    #1 iRst = 1'b0;

    // reset state
    @(negedge iClk);
    check("rst_oValid", 64'(oValid), 64'd0);
    check("rst_oResult", 64'(oResult), 64'd0);
    check("rst_oOverflow", 64'(oOverflow), 64'd0);
    check("rst_oReady", 64'(oReady), 64'd1);
    @(posedge iClk); #1;

    // single beat all ones: result 16 and latency from presentation cycle to oValid cycle
    send(rep(8'h01), rep(8'h01), 1'b0, 1'b1, 1'b0, 1'b1, 32'd16, 1'b0);
    acc_c = cyc;
    n = 0;
    do begin @(negedge iClk); n++; end while (!oValid && n < 20);
    check("latency", 64'(cyc - (acc_c - 1)), 64'(LATENCY));
    drain();

    // vector table of single-beat frames, streamed back to back
    tbl[0] = '{8'h01, 8'h01, 1'b0, 32'd16};
    tbl[1] = '{8'hFF, 8'h02, 1'b1, 32'hFFFF_FFE0};
    tbl[2] = '{8'hFF, 8'h02, 1'b0, 32'd8160};
    tbl[3] = '{8'hFF, 8'hFF, 1'b0, 32'd1040400};
    tbl[4] = '{8'h80, 8'h80, 1'b1, 32'd262144};
    tbl[5] = '{8'h80, 8'h7F, 1'b1, 32'hFFFC_0800};
    tbl[6] = '{8'h03, 8'h05, 1'b0, 32'd240};
    tbl[7] = '{8'hFF, 8'hFF, 1'b1, 32'd16};
    for (int i = 0; i < 8; i++)
      send(rep(tbl[i].x), rep(tbl[i].w), tbl[i].sgn, 1'b1, 1'b0, 1'b1, tbl[i].res, 1'b0);
    drain();

    // 4-beat frame then single-beat frame: results on consecutive cycles
    res_cyc.delete();
    for (int i = 0; i < 4; i++)
      send(rep(8'hFF), rep(8'hFF), 1'b0, (i == 3), 1'b0, 1'b1, 32'd4161600, 1'b0);
    send(rep(8'h01), rep(8'h01), 1'b0, 1'b1, 1'b0, 1'b1, 32'd16, 1'b0);
    drain();
    check("b2b_count", 64'(res_cyc.size()), 64'd2);
    if (res_cyc.size() == 2) check("b2b_gap", 64'(res_cyc[1] - res_cyc[0]), 64'd1);

    // signedness latched on first beat; later iSigned ignored: 2 * (-1*2*16) = -64
    send(rep(8'hFF), rep(8'h02), 1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    send(rep(8'hFF), rep(8'h02), 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFC0, 1'b0);
    drain();

    // 21-bit accumulator: 3 x 1040400 wraps with overflow, next frame clean
    for (int i = 0; i < 3; i++)
      send(rep(8'hFF), rep(8'hFF), 1'b0, (i == 2), 1'b1, 1'b1, 32'd1024048, 1'b1);
    send(rep(8'h01), rep(8'h01), 1'b0, 1'b1, 1'b1, 1'b1, 32'd16, 1'b0);
    drain();

    // random frames against the model
    for (int f = 0; f < 6; f++) rand_frame($urandom_range(1, 4));
    drain();

    // 5-cycle downstream stall while input keeps streaming
    fork
      begin
        for (int f = 0; f < 5; f++) rand_frame(3);
      end
      begin
        logic [ACC_W-1:0] held;
        int k;
        k = 0;
        while (!oValid && k < 200) begin @(posedge iClk); #1; k++; end
        check("stall_start", 64'(oValid), 64'd1);
        if (oValid) begin
          iReady = 1'b0;
          held = oResult;
          repeat (5) begin
            @(negedge iClk);
            check("stall_hold", 64'(oResult), 64'(held));
            check("stall_ready", 64'(oReady), 64'd0);
            check("stall_valid", 64'(oValid), 64'd1);
            @(posedge iClk); #1;
          end
          iReady = 1'b1;
        end
      end
    join
    drain();

    // reset mid-frame: only the following frame's result may appear
    send(rep(8'hFF), rep(8'hFF), 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    send(rep(8'hFF), rep(8'hFF), 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    iRst = 1'b1;
    #3;
    check("midrst_oValid", 64'(oValid), 64'd0);
    check("midrst_oReady", 64'(oReady), 64'd1);
    iRst = 1'b0;
    m_open = 1'b0;
    @(posedge iClk); #1;
    send(rep(8'h01), rep(8'h01), 1'b0, 1'b1, 1'b0, 1'b1, 32'd16, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
